// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states
// and the access-legality check used when a request is accepted.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int WORD_BYTES = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD_WAIT,
        ST_RMW_WRITE
    } lsu_state_t;

    // Misaligned halfword/word, reserved funct3, or a store with an unsigned-load encoding
    function automatic logic is_access_error(input logic we, input logic [2:0] funct3,
                                             input logic [1:0] offset);
        case (funct3)
            F3_B:         return 1'b0;
            F3_H:         return offset[0];
            F3_W:         return offset != 2'b00;
            F3_BU, F3_HU: return we;
            default:      return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane handling for the load/store unit: extracts and extends load data, and
// merges a byte or halfword store into the old memory word.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH_P = 32
) (
    input  logic [2:0]              funct3,
    input  logic [1:0]              offset,
    input  logic [DATA_WIDTH_P-1:0] rd_word,
    output logic [DATA_WIDTH_P-1:0] load_data,
    input  logic [DATA_WIDTH_P-1:0] old_word,
    input  logic [DATA_WIDTH_P-1:0] wdata,
    output logic [DATA_WIDTH_P-1:0] merged_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rd_word[{offset, 3'b000} +: 8];
        half_sel = offset[1] ? rd_word[31:16] : rd_word[15:0];
        case (funct3)
            F3_B:    load_data = {{(DATA_WIDTH_P-8){byte_sel[7]}}, byte_sel};
            F3_BU:   load_data = {{(DATA_WIDTH_P-8){1'b0}}, byte_sel};
            F3_H:    load_data = {{(DATA_WIDTH_P-16){half_sel[15]}}, half_sel};
            F3_HU:   load_data = {{(DATA_WIDTH_P-16){1'b0}}, half_sel};
            default: load_data = rd_word;
        endcase
    end

    always_comb begin
        merged_word = old_word;
        case (funct3)
            F3_B:    merged_word[{offset, 3'b000} +: 8] = wdata[7:0];
            F3_H:    merged_word[{offset[1], 4'b0000} +: 16] = wdata[15:0];
            default: merged_word = wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit for a word-addressed memory without byte enables;
// sub-word stores are performed as read-modify-write.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH_P      = 32,
    parameter int DATA_ADDR_WIDTH_P = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_req_valid,
    output logic                         o_req_ready,
    input  logic                         i_req_we,
    input  logic [2:0]                   i_req_funct3,
    input  logic [DATA_ADDR_WIDTH_P-1:0] i_req_addr,
    input  logic [DATA_WIDTH_P-1:0]      i_req_wdata,
    output logic                         o_resp_valid,
    output logic [DATA_WIDTH_P-1:0]      o_resp_rdata,
    output logic                         o_resp_misaligned,
    output logic                         o_mem_wr_en,
    output logic [DATA_ADDR_WIDTH_P-1:0] o_mem_addr,
    output logic [DATA_WIDTH_P-1:0]      o_mem_wr_data,
    input  logic [DATA_WIDTH_P-1:0]      i_mem_rd_data
);

    lsu_state_t                   state_q, state_d;
    logic                         we_q, we_d;
    logic [2:0]                   funct3_q, funct3_d;
    logic [1:0]                   offset_q, offset_d;
    logic [DATA_ADDR_WIDTH_P-1:0] word_addr_q, word_addr_d;
    logic [DATA_WIDTH_P-1:0]      wdata_q, wdata_d;
    logic                         resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH_P-1:0]      resp_rdata_q, resp_rdata_d;
    logic                         resp_misaligned_q, resp_misaligned_d;

    logic                         req_error;
    logic                         mem_wr_en;
    logic [DATA_WIDTH_P-1:0]      load_data;
    logic [DATA_WIDTH_P-1:0]      merged_word;

    lsu_align #(.DATA_WIDTH_P(DATA_WIDTH_P)) u_align (
        .funct3      (funct3_q),
        .offset      (offset_q),
        .rd_word     (i_mem_rd_data),
        .load_data   (load_data),
        .old_word    (i_mem_rd_data),
        .wdata       (wdata_q),
        .merged_word (merged_word)
    );

    assign req_error = is_access_error(i_req_we, i_req_funct3, i_req_addr[1:0]);

    always_comb begin
        state_d           = state_q;
        we_d              = we_q;
        funct3_d          = funct3_q;
        offset_d          = offset_q;
        word_addr_d       = word_addr_q;
        wdata_d           = wdata_q;
        resp_valid_d      = 1'b0;
        resp_rdata_d      = '0;
        resp_misaligned_d = 1'b0;
        o_req_ready       = 1'b0;
        o_mem_addr        = word_addr_q;
        o_mem_wr_data     = i_req_wdata;
        mem_wr_en         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                o_req_ready = 1'b1;
                o_mem_addr  = {2'b00, i_req_addr[DATA_ADDR_WIDTH_P-1:2]};
                mem_wr_en   = i_req_valid & i_req_we & (i_req_funct3 == F3_W) & ~req_error;
                if (i_req_valid) begin
                    we_d        = i_req_we;
                    funct3_d    = i_req_funct3;
                    offset_d    = i_req_addr[1:0];
                    word_addr_d = {2'b00, i_req_addr[DATA_ADDR_WIDTH_P-1:2]};
                    wdata_d     = i_req_wdata;
                    if (req_error) begin
                        resp_valid_d      = 1'b1;
                        resp_misaligned_d = 1'b1;
                    end else if (i_req_we && i_req_funct3 == F3_W) begin
                        resp_valid_d = 1'b1;
                    end else if (!i_req_we) begin
                        state_d = ST_LOAD_WAIT;
                    end else begin
                        state_d = ST_RMW_WRITE;
                    end
                end
            end
            ST_LOAD_WAIT: begin
                resp_rdata_d = load_data;
                resp_valid_d = 1'b1;
                state_d      = ST_IDLE;
            end
            ST_RMW_WRITE: begin
                mem_wr_en     = we_q;
                o_mem_wr_data = merged_word;
                resp_valid_d  = 1'b1;
                state_d       = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Reset also suppresses a pending RMW write so an aborted access never lands
    assign o_mem_wr_en = mem_wr_en & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q           <= ST_IDLE;
            we_q              <= 1'b0;
            funct3_q          <= '0;
            offset_q          <= '0;
            word_addr_q       <= '0;
            wdata_q           <= '0;
            resp_valid_q      <= 1'b0;
            resp_rdata_q      <= '0;
            resp_misaligned_q <= 1'b0;
        end else begin
            state_q           <= state_d;
            we_q              <= we_d;
            funct3_q          <= funct3_d;
            offset_q          <= offset_d;
            word_addr_q       <= word_addr_d;
            wdata_q           <= wdata_d;
            resp_valid_q      <= resp_valid_d;
            resp_rdata_q      <= resp_rdata_d;
            resp_misaligned_q <= resp_misaligned_d;
        end
    end

    assign o_resp_valid      = resp_valid_q;
    assign o_resp_rdata      = resp_rdata_q;
    assign o_resp_misaligned = resp_misaligned_q;

endmodule
